// File: rtl/unidade_writeback_if.sv
// Bundle of writeback-stage signals: ALU/MDU result ports, scoreboard and
// operand forwarding signals, and the register-file write port.
interface unidade_writeback_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  chk_rs;
  logic [4:0]  chk_rt;
  logic        hazard;
  logic [31:0] rf_rs_data;
  logic [31:0] rf_rt_data;
  logic [31:0] fwd_rs_data;
  logic [31:0] fwd_rt_data;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mdu_valid, mdu_rd, mdu_data,
    output iss_valid, iss_rd, chk_rs, chk_rt,
    output rf_rs_data, rf_rt_data,
    input  mdu_ready, hazard, fwd_rs_data, fwd_rt_data,
    input  we, waddr, wdata
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mdu_valid, mdu_rd, mdu_data,
    input  iss_valid, iss_rd, chk_rs, chk_rt,
    input  rf_rs_data, rf_rt_data,
    output mdu_ready, hazard, fwd_rs_data, fwd_rt_data,
    output we, waddr, wdata
  );
endinterface

// File: rtl/unidade_writeback.sv
// Writeback arbiter: ALU results take priority, MDU results queue in a small FIFO.
// Pending-write scoreboard for decode hazards; macro WB_BYPASS_EN adds write-port forwarding.
module unidade_writeback #(
  parameter int FIFO_DEPTH = 2
) (
  input logic                  clock,
  input logic                  reset,
  unidade_writeback_if.slave   bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [4:0]       fifo_rd   [FIFO_DEPTH];
  logic [31:0]      fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic [4:0]  head_rd;
  logic [31:0] head_data;

  logic        we_reg;
  logic [4:0]  waddr_reg;
  logic [31:0] wdata_reg;

  logic        pending_reg [1:31];
  logic [31:0] pending;

  assign full      = (count_reg == CNT_W'(FIFO_DEPTH));
  assign empty     = (count_reg == '0);
  // Push is gated on full alone, so a pop in a full cycle never frees room for a same-cycle push.
  assign push      = bus.mdu_valid && !full;
  assign pop       = !bus.alu_valid && !empty;
  assign head_rd   = fifo_rd[rd_ptr_reg];
  assign head_data = fifo_data[rd_ptr_reg];

  assign bus.mdu_ready = !full;

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_rd[wr_ptr_reg]   <= bus.mdu_rd;
      fifo_data[wr_ptr_reg] <= bus.mdu_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // A winner targeting r0 still updates the address/data but never strobes we.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      we_reg    <= 1'b0;
      waddr_reg <= '0;
      wdata_reg <= '0;
    end else if (bus.alu_valid) begin
      we_reg    <= (bus.alu_rd != 5'd0);
      waddr_reg <= bus.alu_rd;
      wdata_reg <= bus.alu_data;
    end else if (pop) begin
      we_reg    <= (head_rd != 5'd0);
      waddr_reg <= head_rd;
      wdata_reg <= head_data;
    end else begin
      we_reg    <= 1'b0;
    end
  end

  assign bus.we    = we_reg;
  assign bus.waddr = waddr_reg;
  assign bus.wdata = wdata_reg;

  // Issue sets and MDU pop clears; a coincident set takes precedence.
  assign pending[0] = 1'b0;
  for (genvar gi = 1; gi < 32; gi++) begin : g_pending
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        pending_reg[gi] <= 1'b0;
      end else if (bus.iss_valid && (bus.iss_rd == 5'(gi))) begin
        pending_reg[gi] <= 1'b1;
      end else if (pop && (head_rd == 5'(gi))) begin
        pending_reg[gi] <= 1'b0;
      end
    end
    assign pending[gi] = pending_reg[gi];
  end

  assign bus.hazard = pending[bus.chk_rs] | pending[bus.chk_rt];

`ifdef WB_BYPASS_EN
  assign bus.fwd_rs_data = (we_reg && (waddr_reg == bus.chk_rs) && (bus.chk_rs != 5'd0))
                           ? wdata_reg : bus.rf_rs_data;
  assign bus.fwd_rt_data = (we_reg && (waddr_reg == bus.chk_rt) && (bus.chk_rt != 5'd0))
                           ? wdata_reg : bus.rf_rt_data;
`else
  assign bus.fwd_rs_data = bus.rf_rs_data;
  assign bus.fwd_rt_data = bus.rf_rt_data;
`endif

endmodule
